map_ram_arbiter: RTL and testbench
==================================

Name: map_ram_arbiter

Overview:
- Shares the single read/write port of the level map RAM (8-bit tile codes) between two requesters: game logic (read/write) and the display renderer that builds VRAM (read-only).
- Sits between main, VGADisp and the RAM instance on the same clock; main and VGADisp each see a private request/ack/return-data interface.
- Display has priority. A starvation counter guarantees game logic a grant within bounded time.

Parameters:
- AW, 10, RAM address width.
- DW, 8, RAM data width.
- RD_LAT, 1, RAM read latency in cycles, from the registered address at the RAM pins to valid ram_dout; legal range 1..3.
- MAX_WAIT, 4, consecutive un-acked game_req cycles after which game wins over display; legal range 1..15.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- clrn  in  1  asynchronous, active-low reset.
- game_req  in  1  game access request; held until game_ack.
- game_we  in  1  1 = write, 0 = read; qualified by game_req.
- game_addr  in  AW  game address.
- game_wdata  in  DW  game write data.
- game_ack  out  1  combinational; request accepted this cycle.
- game_rdata  out  DW  game read data.
- game_rvalid  out  1  one-cycle pulse; game_rdata valid.
- disp_req  in  1  display read request; held until disp_ack.
- disp_addr  in  AW  display address.
- disp_ack  out  1  combinational; request accepted this cycle.
- disp_rdata  out  DW  display read data.
- disp_rvalid  out  1  one-cycle pulse; disp_rdata valid.
- ram_addr  out  AW  registered RAM address.
- ram_din  out  DW  registered RAM write data.
- ram_we  out  1  registered RAM write enable.
- ram_dout  in  DW  RAM read data.

Behaviour:
- Reset (clrn=0, asynchronous):
  - wait_cnt clears to 0.
  - The tag pipeline clears.
  - All registered outputs clear to 0: ram_addr, ram_din, ram_we, game_rdata, disp_rdata, game_rvalid, disp_rvalid.
  - game_ack and disp_ack are forced to 0 while clrn=0.
- Grant decision, combinational each cycle; at most one grant per cycle:
  - game_pri = (wait_cnt >= MAX_WAIT).
  - disp_ack = disp_req & ~(game_req & game_pri).
  - game_ack = game_req & ~disp_ack.
- wait_cnt (4-bit, saturating at MAX_WAIT):
  - Increments when game_req=1 and game_ack=0.
  - Clears when game_ack=1 or game_req=0.
- RAM port, registered:
  - In the cycle after an ack, ram_addr/ram_we/ram_din carry the granted request.
  - ram_we=1 only for an acked game write.
  - With no ack: ram_we=0, and ram_addr/ram_din hold their previous values.
- Tag pipeline:
  - RD_LAT+1 stages of {valid, owner}.
  - Stage 0 loads valid=1 on an acked read, owner = game/disp; writes and idle cycles load valid=0.
  - When the last stage is valid, the owner's rdata register captures ram_dout and its rvalid pulses for exactly 1 cycle.
  - Read data therefore returns exactly RD_LAT+1 cycles after the ack cycle.
- Throughput and ordering:
  - Back-to-back acks are allowed every cycle, so each requester may present a new request in the cycle after its ack.
  - Returns stay in issue order; both rvalids are never high in the same cycle.
- Ordering hazard: a game write acked in cycle t, followed by any read acked in t+1 or later, returns the new data. The RAM is write-first / write-then-read by cycle, and the arbiter adds no reordering.
- Simultaneous requests:
  - Display wins until wait_cnt reaches MAX_WAIT; game then wins exactly one cycle.
  - wait_cnt clears on that game ack.
  - Under continuous contention, game is therefore granted once every MAX_WAIT+1 cycles.
- Request rules and boundaries:
  - Requesters must not change addr/we/wdata while req=1 and ack=0.
  - Dropping req before ack is legal and cancels the request.
  - wait_cnt clears in that case.
- Reset mid-operation:
  - In-flight tags are discarded.
  - No rvalid is produced for reads acked before reset.
  - The first cycle after release behaves as idle with wait_cnt=0.

Test Plan:
- Game write then read (RD_LAT=1): game writes 0x3C at addr 0x012 with disp idle → game_ack same cycle; ram_we=1, ram_addr=0x012 next cycle. Then game reads 0x012 → game_rvalid exactly 2 cycles after ack, game_rdata=0x3C; disp_rvalid stays 0.
- Display read stream: disp_req held high, addresses 0..7 advancing on each ack → disp_ack every cycle. 8 disp_rvalid pulses in address order, first pulse 2 cycles after the first ack.
- Starvation (MAX_WAIT=4): disp_req continuous; game_req read of 0x100 raised at cycle 0 → disp_ack in cycles 0–3; game_ack in cycle 4 with disp_ack=0; disp_ack resumes in cycle 5; wait_cnt=0 after cycle 4.
- Sustained contention over 50 cycles, both requesters re-requesting immediately → exactly 10 game acks, 40 disp acks, never both acks in one cycle.
- Cancel: game_req high for 2 contended cycles, then dropped → wait_cnt returns to 0; no game ack or rvalid.
- Reset mid-flight: disp read acked, clrn pulled low the next cycle → all outputs 0 at once. After release, no disp_rvalid ever appears for that read.

Source files
------------

// File: rtl/map_ram_arbiter.sv
// map_ram_arbiter
//   Shares the single read/write port of the level map RAM between game logic
//   (read/write) and the display renderer (read-only). Display has priority.
//   A starvation counter hands the port to game logic after MAX_WAIT
//   consecutive un-acked requests.
//
//   The ram_addr/ram_we/ram_din register acts as the RAM's address register.
//   ram_dout is valid RD_LAT cycles after the edge that loads it. Read data
//   reaches the requester RD_LAT+1 cycles after its ack cycle.
//
// Ports
//   clk, clrn                        clock, asynchronous active-low reset
//   game_req/we/addr/wdata           game request (held until game_ack)
//   game_ack                         combinational grant to game
//   game_rdata/game_rvalid           game read return (one-cycle pulse)
//   disp_req/addr                    display read request (held until disp_ack)
//   disp_ack                         combinational grant to display
//   disp_rdata/disp_rvalid           display read return (one-cycle pulse)
//   ram_addr/ram_din/ram_we          registered RAM port
//   ram_dout                         RAM read data
module map_ram_arbiter #(
  parameter int AW       = 10,
  parameter int DW       = 8,
  parameter int RD_LAT   = 1,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic          game_req,
  input  logic          game_we,
  input  logic [AW-1:0] game_addr,
  input  logic [DW-1:0] game_wdata,
  output logic          game_ack,
  output logic [DW-1:0] game_rdata,
  output logic          game_rvalid,
  input  logic          disp_req,
  input  logic [AW-1:0] disp_addr,
  output logic          disp_ack,
  output logic [DW-1:0] disp_rdata,
  output logic          disp_rvalid,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  output logic          ram_we,
  input  logic [DW-1:0] ram_dout
);

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  logic [3:0]        wait_cnt_q, wait_cnt_d;
  logic              game_pri;

  logic [AW-1:0]     ram_addr_q, ram_addr_d;
  logic [DW-1:0]     ram_din_q,  ram_din_d;
  logic              ram_we_q,   ram_we_d;

  // Tag pipeline: the ack cycle itself is stage 0, these registers are
  // stages 1..RD_LAT. Owner bit 1 = game, 0 = display.
  logic [RD_LAT-1:0] tag_vld_q, tag_vld_d;
  logic [RD_LAT-1:0] tag_own_q, tag_own_d;

  logic [DW-1:0]     game_rdata_q, game_rdata_d;
  logic [DW-1:0]     disp_rdata_q, disp_rdata_d;
  logic              game_rvalid_q, game_rvalid_d;
  logic              disp_rvalid_q, disp_rvalid_d;

  // Grant decision; acks are suppressed while reset is asserted.
  always_comb begin
    game_pri = (wait_cnt_q >= MAX_WAIT_C);
    disp_ack = clrn & disp_req & ~(game_req & game_pri);
    game_ack = clrn & game_req & ~disp_ack;
  end

  always_comb begin
    // Starvation counter, saturating at MAX_WAIT.
    wait_cnt_d = wait_cnt_q;
    if (!game_req || game_ack) begin
      wait_cnt_d = 4'd0;
    end else if (wait_cnt_q < MAX_WAIT_C) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end

    // RAM port: address/data hold when idle, write enable only for a game write.
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    ram_we_d   = 1'b0;
    if (game_ack) begin
      ram_addr_d = game_addr;
      ram_din_d  = game_wdata;
      ram_we_d   = game_we;
    end else if (disp_ack) begin
      ram_addr_d = disp_addr;
    end

    // Tag shift: new entry marks an acked read and who owns it.
    tag_vld_d    = tag_vld_q;
    tag_own_d    = tag_own_q;
    tag_vld_d[0] = disp_ack | (game_ack & ~game_we);
    tag_own_d[0] = game_ack;
    for (int i = 1; i < RD_LAT; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_own_d[i] = tag_own_q[i-1];
    end

    // Return: the last tag stage lines up with valid ram_dout.
    game_rvalid_d = tag_vld_q[RD_LAT-1] &  tag_own_q[RD_LAT-1];
    disp_rvalid_d = tag_vld_q[RD_LAT-1] & ~tag_own_q[RD_LAT-1];
    game_rdata_d  = game_rvalid_d ? ram_dout : game_rdata_q;
    disp_rdata_d  = disp_rvalid_d ? ram_dout : disp_rdata_q;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wait_cnt_q    <= '0;
      ram_addr_q    <= '0;
      ram_din_q     <= '0;
      ram_we_q      <= 1'b0;
      tag_vld_q     <= '0;
      tag_own_q     <= '0;
      game_rdata_q  <= '0;
      disp_rdata_q  <= '0;
      game_rvalid_q <= 1'b0;
      disp_rvalid_q <= 1'b0;
    end else begin
      wait_cnt_q    <= wait_cnt_d;
      ram_addr_q    <= ram_addr_d;
      ram_din_q     <= ram_din_d;
      ram_we_q      <= ram_we_d;
      tag_vld_q     <= tag_vld_d;
      tag_own_q     <= tag_own_d;
      game_rdata_q  <= game_rdata_d;
      disp_rdata_q  <= disp_rdata_d;
      game_rvalid_q <= game_rvalid_d;
      disp_rvalid_q <= disp_rvalid_d;
    end
  end

  assign ram_addr    = ram_addr_q;
  assign ram_din     = ram_din_q;
  assign ram_we      = ram_we_q;
  assign game_rdata  = game_rdata_q;
  assign disp_rdata  = disp_rdata_q;
  assign game_rvalid = game_rvalid_q;
  assign disp_rvalid = disp_rvalid_q;

endmodule

// File: tb/tb_map_ram_arbiter.sv
// Directed bench for map_ram_arbiter (AW=10, DW=8, RD_LAT=1, MAX_WAIT=4).
// The RAM model reads combinationally from the registered address and
// writes on the clock edge; it is preloaded with mem[i] = i[7:0] ^ 8'hA5.
module tb_map_ram_arbiter;

  logic       clk = 1'b0;
  logic       clrn;
  logic       game_req, game_we;
  logic [9:0] game_addr;
  logic [7:0] game_wdata;
  logic       game_ack;
  logic [7:0] game_rdata;
  logic       game_rvalid;
  logic       disp_req;
  logic [9:0] disp_addr;
  logic       disp_ack;
  logic [7:0] disp_rdata;
  logic       disp_rvalid;
  logic [9:0] ram_addr;
  logic [7:0] ram_din;
  logic       ram_we;
  logic [7:0] ram_dout;

  logic [7:0] mem [0:1023];
  logic       preload;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  map_ram_arbiter #(.AW(10), .DW(8), .RD_LAT(1), .MAX_WAIT(4)) dut (
    .clk(clk), .clrn(clrn),
    .game_req(game_req), .game_we(game_we), .game_addr(game_addr),
    .game_wdata(game_wdata), .game_ack(game_ack), .game_rdata(game_rdata),
    .game_rvalid(game_rvalid),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_ack(disp_ack),
    .disp_rdata(disp_rdata), .disp_rvalid(disp_rvalid),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
    .ram_dout(ram_dout)
  );

  assign ram_dout = mem[ram_addr];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 8'(i) ^ 8'hA5;
    end else if (ram_we) begin
      mem[ram_addr] <= ram_din;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    int g_cnt, d_cnt, both_ack, both_rv;
    clrn = 1'b0; preload = 1'b1;
    game_req = 1'b1; game_we = 1'b0; game_addr = '0; game_wdata = '0;
    disp_req = 1'b1; disp_addr = '0;

    // Reset: acks forced low even with requests present
    next_cyc();
    preload = 1'b0;
    mid();
    check("rst_gack", 32'(game_ack), 32'd0);
    check("rst_dack", 32'(disp_ack), 32'd0);
    check("rst_raddr", 32'(ram_addr), 32'd0);
    check("rst_rwe", 32'(ram_we), 32'd0);
    check("rst_rdin", 32'(ram_din), 32'd0);
    check("rst_grv", 32'(game_rvalid), 32'd0);
    check("rst_drv", 32'(disp_rvalid), 32'd0);

    next_cyc();
    clrn = 1'b1; game_req = 1'b0; disp_req = 1'b0;
    mid();
    check("rel_wcnt", 32'(dut.wait_cnt_q), 32'd0);

    // Test 1: game write 0x3C @0x012, then read it back
    next_cyc();
    game_req = 1'b1; game_we = 1'b1; game_addr = 10'h012; game_wdata = 8'h3C;
    mid();
    check("t1_wr_gack", 32'(game_ack), 32'd1);
    check("t1_wr_dack", 32'(disp_ack), 32'd0);
    next_cyc();
    game_we = 1'b0;
    mid();
    check("t1_ram_we", 32'(ram_we), 32'd1);
    check("t1_ram_addr", 32'(ram_addr), 32'h012);
    check("t1_ram_din", 32'(ram_din), 32'h3C);
    check("t1_rd_gack", 32'(game_ack), 32'd1);
    next_cyc();
    game_req = 1'b0;
    mid();
    check("t1_ram_we_off", 32'(ram_we), 32'd0);
    check("t1_grv_early", 32'(game_rvalid), 32'd0);
    next_cyc();
    mid();
    check("t1_grv", 32'(game_rvalid), 32'd1);
    check("t1_grdata", 32'(game_rdata), 32'h3C);
    check("t1_drv", 32'(disp_rvalid), 32'd0);
    next_cyc();
    mid();
    check("t1_grv_pulse", 32'(game_rvalid), 32'd0);

    // Test 2: display stream addresses 0..7
    for (int k = 0; k < 12; k++) begin
      next_cyc();
      disp_req  = (k < 8);
      disp_addr = 10'((k < 8) ? k : 7);
      mid();
      check("t2_dack", 32'(disp_ack), 32'(k < 8));
      check("t2_grv", 32'(game_rvalid), 32'd0);
      if (k >= 2 && k < 10) begin
        check("t2_drv", 32'(disp_rvalid), 32'd1);
        check("t2_drdata", 32'(disp_rdata), 32'(8'(k - 2) ^ 8'hA5));
      end else begin
        check("t2_drv_idle", 32'(disp_rvalid), 32'd0);
      end
    end

    // Test 3: starvation, game read @0x100 against continuous display
    for (int c = 0; c < 8; c++) begin
      next_cyc();
      disp_req = (c < 6); disp_addr = 10'h020;
      game_req = (c <= 4); game_we = 1'b0; game_addr = 10'h100;
      mid();
      check("t3_gack", 32'(game_ack), 32'(c == 4));
      check("t3_dack", 32'(disp_ack), 32'(c < 6 && c != 4));
      check("t3_wcnt", 32'(dut.wait_cnt_q), 32'((c <= 4) ? c : 0));
      check("t3_grv", 32'(game_rvalid), 32'(c == 6));
      check("t3_drv", 32'(disp_rvalid), 32'((c >= 2 && c <= 5) || c == 7));
      if (c == 6) check("t3_grdata", 32'(game_rdata), 32'hA5);
      if (c == 7) check("t3_drdata", 32'(disp_rdata), 32'h85);
    end
    next_cyc(); next_cyc();

    // Test 4: sustained contention for 50 cycles
    g_cnt = 0; d_cnt = 0; both_ack = 0; both_rv = 0;
    for (int c = 0; c < 50; c++) begin
      next_cyc();
      game_req = 1'b1; game_we = 1'b0; game_addr = 10'h030;
      disp_req = 1'b1; disp_addr = 10'h040;
      mid();
      check("t4_gack_slot", 32'(game_ack), 32'((c % 5) == 4));
      if (game_ack) g_cnt++;
      if (disp_ack) d_cnt++;
      if (game_ack && disp_ack) both_ack++;
      if (game_rvalid && disp_rvalid) both_rv++;
    end
    check("t4_game_acks", 32'(g_cnt), 32'd10);
    check("t4_disp_acks", 32'(d_cnt), 32'd40);
    check("t4_both_ack", 32'(both_ack), 32'd0);
    check("t4_both_rv", 32'(both_rv), 32'd0);
    next_cyc();
    game_req = 1'b0; disp_req = 1'b0;
    next_cyc(); next_cyc(); next_cyc();

    // Test 5: game request cancelled after 2 contended cycles
    for (int c = 0; c < 6; c++) begin
      next_cyc();
      disp_req = (c < 2); disp_addr = 10'h050;
      game_req = (c < 2); game_addr = 10'h060;
      mid();
      check("t5_gack", 32'(game_ack), 32'd0);
      check("t5_grv", 32'(game_rvalid), 32'd0);
      check("t5_wcnt", 32'(dut.wait_cnt_q), 32'((c < 3) ? c : 0));
    end

    // Test 6: reset right after a display ack
    next_cyc();
    disp_req = 1'b1; disp_addr = 10'h005;
    mid();
    check("t6_dack", 32'(disp_ack), 32'd1);
    next_cyc();
    clrn = 1'b0; disp_req = 1'b1; game_req = 1'b1;
    #1;
    check("t6_raddr", 32'(ram_addr), 32'd0);
    check("t6_rdin", 32'(ram_din), 32'd0);
    check("t6_rwe", 32'(ram_we), 32'd0);
    check("t6_grdata", 32'(game_rdata), 32'd0);
    check("t6_drdata", 32'(disp_rdata), 32'd0);
    check("t6_gack", 32'(game_ack), 32'd0);
    check("t6_dack_rst", 32'(disp_ack), 32'd0);
    next_cyc();
    clrn = 1'b1; disp_req = 1'b0; game_req = 1'b0;
    mid();
    check("t6_wcnt", 32'(dut.wait_cnt_q), 32'd0);
    check("t6_drv0", 32'(disp_rvalid), 32'd0);
    for (int c = 0; c < 3; c++) begin
      next_cyc();
      mid();
      check("t6_drv", 32'(disp_rvalid), 32'd0);
      check("t6_grv", 32'(game_rvalid), 32'd0);
    end

    // Post-reset read works normally
    next_cyc();
    disp_req = 1'b1; disp_addr = 10'h007;
    mid();
    check("t7_dack", 32'(disp_ack), 32'd1);
    next_cyc();
    disp_req = 1'b0;
    next_cyc();
    mid();
    check("t7_drv", 32'(disp_rvalid), 32'd1);
    check("t7_drdata", 32'(disp_rdata), 32'hA2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
